// File: rtl/sprite_layer_sched_pkg.sv
// Shared constants and config record for the sprite layer scheduler.
// Field select codes, screen size and the per-sprite window record.
package sprite_layer_sched_pkg;

  localparam logic [2:0] CFG_POSX = 3'd0;
  localparam logic [2:0] CFG_POSY = 3'd1;
  localparam logic [2:0] CFG_W    = 3'd2;
  localparam logic [2:0] CFG_H    = 3'd3;
  localparam logic [2:0] CFG_BASE = 3'd4;
  localparam logic [2:0] CFG_EN   = 3'd5;

  localparam logic [10:0] VGA_W = 11'd640;
  localparam logic [9:0]  VGA_H = 10'd480;

  localparam int ADDR_W = 14;

  typedef struct packed {
    logic              en;
    logic [9:0]        pos_x;
    logic [8:0]        pos_y;
    logic [9:0]        width;
    logic [8:0]        height;
    logic [ADDR_W-1:0] base;
  } spr_cfg_t;

endpackage

// File: rtl/sprite_layer_sched_cmp.sv
// Window test for one sprite: hit flag plus the pixel's row/col
// inside the window. Sums are one bit wider so edges never wrap.
module spr_window_cmp
  import sprite_layer_sched_pkg::*;
(
  input  spr_cfg_t   cfg,
  input  logic [9:0] x,
  input  logic [8:0] y,
  output logic       hit,
  output logic [8:0] row,
  output logic [9:0] col
);

  logic [10:0] x_end;
  logic [9:0]  y_end;
  logic        in_x;
  logic        in_y;
  logic        on_scr;

  assign x_end = {1'b0, cfg.pos_x} + {1'b0, cfg.width};
  assign y_end = {1'b0, cfg.pos_y} + {1'b0, cfg.height};

  assign in_x = (x >= cfg.pos_x) && ({1'b0, x} < x_end);
  assign in_y = (y >= cfg.pos_y) && ({1'b0, y} < y_end);

  // portions of a window hanging past the visible area never hit
  assign on_scr = ({1'b0, x} < VGA_W) && ({1'b0, y} < VGA_H);

  assign hit = cfg.en
             && (cfg.width  != '0)
             && (cfg.height != '0)
             && in_x && in_y && on_scr;

  assign row = y - cfg.pos_y;
  assign col = x - cfg.pos_x;

endmodule

// File: rtl/sprite_layer_sched.sv
// Per-pixel sprite window arbiter sharing one image SRAM.
// Double-buffered config, 3-stage compare/address/colour pipeline.
module sprite_layer_sched
  import sprite_layer_sched_pkg::*;
#(
  parameter int NUM_SPR    = 4,
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] TRANS_KEY = '0,
  localparam int IW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            vga_x,
  input  logic [8:0]            vga_y,
  input  logic                  frame_start,
  input  logic                  cfg_we,
  input  logic [IW-1:0]         cfg_idx,
  input  logic [2:0]            cfg_sel,
  input  logic [15:0]           cfg_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] color,
  output logic                  color_on,
  output logic [IW-1:0]         hit_idx
);

  spr_cfg_t shadow [NUM_SPR];
  spr_cfg_t active [NUM_SPR];

  logic [NUM_SPR-1:0] hits;
  logic [8:0]         rows [NUM_SPR];
  logic [9:0]         cols [NUM_SPR];

  logic               any_hit;
  logic [IW-1:0]      win;

  logic               s1_hit;
  logic [IW-1:0]      s1_idx;
  logic [8:0]         s1_row;
  logic [9:0]         s1_col;
  logic [9:0]         s1_w;
  logic [ADDR_W-1:0]  s1_base;

  logic               s2_hit;
  logic [IW-1:0]      s2_idx;

  logic [ADDR_WIDTH-1:0] prod;
  logic                  unused_cfg;

  assign unused_cfg = ^cfg_data[15:ADDR_W];

  // commit reads shadow before this edge's write, so a write
  // coincident with frame_start waits for the next frame
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SPR; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (frame_start) begin
        for (int i = 0; i < NUM_SPR; i++) begin
          active[i] <= shadow[i];
        end
      end
      if (cfg_we) begin
        case (cfg_sel)
          CFG_POSX: shadow[cfg_idx].pos_x  <= cfg_data[9:0];
          CFG_POSY: shadow[cfg_idx].pos_y  <= cfg_data[8:0];
          CFG_W:    shadow[cfg_idx].width  <= cfg_data[9:0];
          CFG_H:    shadow[cfg_idx].height <= cfg_data[8:0];
          CFG_BASE: shadow[cfg_idx].base   <= cfg_data[ADDR_W-1:0];
          CFG_EN:   shadow[cfg_idx].en     <= cfg_data[0];
          default: ;
        endcase
      end
    end
  end

  for (genvar i = 0; i < NUM_SPR; i++) begin : g_cmp
    spr_window_cmp u_cmp (
      .cfg (active[i]),
      .x   (vga_x),
      .y   (vga_y),
      .hit (hits[i]),
      .row (rows[i]),
      .col (cols[i])
    );
  end

  // scan downwards so the lowest hitting index is written last
  always_comb begin
    any_hit = 1'b0;
    win     = '0;
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (hits[i]) begin
        any_hit = 1'b1;
        win     = IW'(i);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_hit  <= 1'b0;
      s1_idx  <= '0;
      s1_row  <= '0;
      s1_col  <= '0;
      s1_w    <= '0;
      s1_base <= '0;
    end else begin
      s1_hit  <= any_hit;
      s1_idx  <= win;
      s1_row  <= rows[win];
      s1_col  <= cols[win];
      s1_w    <= active[win].width;
      s1_base <= active[win].base;
    end
  end

  assign prod = ADDR_WIDTH'(s1_row) * ADDR_WIDTH'(s1_w);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_hit   <= 1'b0;
      s2_idx   <= '0;
      ram_addr <= '0;
    end else begin
      s2_hit <= s1_hit;
      s2_idx <= s1_idx;
      if (s1_hit) begin
        ram_addr <= ADDR_WIDTH'(s1_base) + prod
                  + ADDR_WIDTH'(s1_col);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      color    <= '0;
      color_on <= 1'b0;
      hit_idx  <= '0;
    end else begin
      if (s2_hit) begin
        color <= ram_data;
      end
      color_on <= s2_hit && (ram_data != TRANS_KEY);
      hit_idx  <= s2_idx;
    end
  end

endmodule

// File: tb/tb_sprite_layer_sched.sv
// Bench for sprite_layer_sched: directed scenarios then random traffic,
// checked against a window-level reference model with an SRAM array.
module tb_sprite_layer_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [9:0]  vga_x;
  logic [8:0]  vga_y;
  logic        frame_start;
  logic        cfg_we;
  logic [1:0]  cfg_idx;
  logic [2:0]  cfg_sel;
  logic [15:0] cfg_data;
  logic [13:0] ram_addr;
  logic [11:0] ram_data;
  logic [11:0] color;
  logic        color_on;
  logic [1:0]  hit_idx;

  logic [11:0] mem [16384];

  always #5 clk = ~clk;

  assign ram_data = mem[ram_addr];

  sprite_layer_sched dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .vga_x       (vga_x),
    .vga_y       (vga_y),
    .frame_start (frame_start),
    .cfg_we      (cfg_we),
    .cfg_idx     (cfg_idx),
    .cfg_sel     (cfg_sel),
    .cfg_data    (cfg_data),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .color       (color),
    .color_on    (color_on),
    .hit_idx     (hit_idx)
  );

  // fields: 0 pos_x, 1 pos_y, 2 width, 3 height, 4 base, 5 enable
  int sh [4][6];
  int ac [4][6];

  int n_chk  = 0;
  int n_pass = 0;

  bit p1_hit, p2_hit;
  int p1_idx, p2_idx, p1_addr;
  int m_addr, m_color, m_idx;
  bit m_on, m_hv;

  function automatic int fmask(int s);
    case (s)
      0: return 1023;
      1: return 511;
      2: return 1023;
      3: return 511;
      4: return 16383;
      default: return 1;
    endcase
  endfunction

  function automatic void model_pix(input int x, input int y,
                                    output bit h, output int idx,
                                    output int addr);
    h = 0;
    idx = 0;
    addr = 0;
    for (int i = 0; i < 4; i++) begin
      if (!h && ac[i][5] != 0 && ac[i][2] > 0 && ac[i][3] > 0
          && x >= ac[i][0] && x < ac[i][0] + ac[i][2]
          && y >= ac[i][1] && y < ac[i][1] + ac[i][3]
          && x < 640 && y < 480) begin
        h = 1;
        idx = i;
        addr = (ac[i][4] + (y - ac[i][1]) * ac[i][2]
               + (x - ac[i][0])) % 16384;
      end
    end
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    bit h;
    int id, a;
    model_pix(int'(vga_x), int'(vga_y), h, id, a);
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        for (int f = 0; f < 6; f++) begin
          sh[i][f] = 0;
          ac[i][f] = 0;
        end
      p1_hit = 0;
      p2_hit = 0;
      m_addr = 0;
      m_color = 0;
      m_on = 0;
      m_idx = 0;
      m_hv = 1;
    end else begin
      if (p2_hit) m_color = int'(mem[m_addr]);
      m_on = p2_hit && (mem[m_addr] != 12'h000);
      m_hv = p2_hit;
      m_idx = p2_idx;
      p2_hit = p1_hit;
      p2_idx = p1_idx;
      if (p1_hit) m_addr = p1_addr;
      p1_hit = h;
      p1_idx = id;
      p1_addr = a;
      if (frame_start) ac = sh;
      if (cfg_we && cfg_sel < 3'd6)
        sh[cfg_idx][cfg_sel] = int'(cfg_data) & fmask(int'(cfg_sel));
    end
    #1;
    chk("ram_addr", 32'(ram_addr), m_addr);
    chk("color_on", 32'(color_on), 32'(m_on));
    chk("color", 32'(color), m_color);
    if (m_hv) chk("hit_idx", 32'(hit_idx), m_idx);
  endtask

  task automatic wr(int i, int s, int d);
    cfg_we = 1'b1;
    cfg_idx = 2'(i);
    cfg_sel = 3'(s);
    cfg_data = 16'(d);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
  endtask

  task automatic pix(int x, int y);
    vga_x = 10'(x);
    vga_y = 9'(y);
    step();
  endtask

  task automatic set_spr(int i, int px, int py, int w, int h,
                         int b, int en);
    wr(i, 0, px);
    wr(i, 1, py);
    wr(i, 2, w);
    wr(i, 3, h);
    wr(i, 4, b);
    wr(i, 5, en);
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) begin
      mem[i] = ($urandom_range(0, 7) == 0) ? 12'h000
                                           : 12'($urandom);
    end
    mem[82]   = 12'h5A5;
    mem[3105] = 12'h0F0;
    mem[1650] = 12'h00F;
    mem[3106] = 12'h000;
    mem[1651] = 12'hABC;
    mem[115]  = 12'h123;

    rst_n = 1'b0;
    vga_x = '0;
    vga_y = '0;
    frame_start = 1'b0;
    cfg_we = 1'b0;
    cfg_idx = '0;
    cfg_sel = '0;
    cfg_data = '0;
    p1_hit = 0;
    p2_hit = 0;
    p1_idx = 0;
    p2_idx = 0;
    p1_addr = 0;

    repeat (3) step();
    chk("rst_color_on", 32'(color_on), 0);
    chk("rst_ram_addr", 32'(ram_addr), 0);
    chk("rst_hit_idx", 32'(hit_idx), 0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++)
      pix($urandom_range(0, 639), $urandom_range(0, 479));
    chk("no_hit_before_commit", 32'(color_on), 0);

    set_spr(0, 399, 252, 80, 11, 0, 1);
    commit();
    pix(401, 253);
    pix(0, 0);
    chk("single_addr", 32'(ram_addr), 82);
    pix(0, 0);
    chk("single_color", 32'(color), 32'h5A5);
    chk("single_on", 32'(color_on), 1);

    set_spr(1, 0, 0, 64, 64, 1000, 1);
    set_spr(0, 5, 5, 20, 20, 3000, 1);
    commit();
    pix(10, 10);
    pix(0, 200);
    pix(0, 200);
    chk("overlap_idx0", 32'(hit_idx), 0);
    chk("overlap_color0", 32'(color), 32'h0F0);
    wr(0, 5, 0);
    commit();
    pix(10, 10);
    pix(0, 200);
    pix(0, 200);
    chk("overlap_idx1", 32'(hit_idx), 1);
    chk("overlap_color1", 32'(color), 32'h00F);

    wr(0, 5, 1);
    commit();
    pix(11, 10);
    pix(0, 200);
    pix(0, 200);
    chk("transparent_on", 32'(color_on), 0);

    wr(0, 0, 100);
    pix(10, 10);
    pix(10, 10);
    pix(10, 10);
    chk("dbuf_old_idx", 32'(hit_idx), 0);
    chk("dbuf_old_on", 32'(color_on), 1);
    cfg_we = 1'b1;
    cfg_idx = 2'd0;
    cfg_sel = 3'd0;
    cfg_data = 16'd200;
    frame_start = 1'b1;
    step();
    cfg_we = 1'b0;
    frame_start = 1'b0;
    pix(105, 10);
    pix(105, 10);
    pix(105, 10);
    chk("dbuf_mid_on", 32'(color_on), 1);
    chk("dbuf_mid_color", 32'(color), 32'h0F0);
    commit();
    pix(105, 10);
    pix(105, 10);
    pix(105, 10);
    chk("dbuf_new_on", 32'(color_on), 0);

    wr(0, 5, 0);
    wr(1, 5, 0);
    set_spr(2, 0, 0, 0, 50, 0, 1);
    set_spr(3, 600, 400, 80, 50, 16380, 1);
    commit();
    for (int x = 590; x < 650; x++) pix(x, 401);
    for (int y = 0; y < 50; y += 7) pix(y, 10);
    pix(610, 400);
    pix(0, 0);
    chk("wrap_addr", 32'(ram_addr), 6);
    pix(639, 401);
    pix(0, 0);
    pix(0, 0);
    chk("edge_639_color", 32'(color), 32'h123);
    chk("edge_639_on", 32'(color_on), 1);
    pix(640, 401);
    pix(0, 0);
    pix(0, 0);
    chk("edge_640_on", 32'(color_on), 0);

    for (int k = 0; k < 3000; k++) begin
      int r;
      r = $urandom_range(0, 999);
      vga_x = 10'($urandom_range(0, 700));
      vga_y = 9'($urandom_range(0, 511));
      if (r < 3) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else if (r < 20) begin
        frame_start = 1'b1;
        cfg_we = ($urandom_range(0, 1) == 1);
        cfg_idx = 2'($urandom_range(0, 3));
        cfg_sel = 3'($urandom_range(0, 7));
        cfg_data = 16'($urandom_range(0, 300));
        step();
        frame_start = 1'b0;
        cfg_we = 1'b0;
      end else if (r < 150) begin
        cfg_we = 1'b1;
        cfg_idx = 2'($urandom_range(0, 3));
        cfg_sel = 3'($urandom_range(0, 7));
        if (cfg_sel == 3'd4) cfg_data = 16'($urandom);
        else if (cfg_sel == 3'd5) cfg_data = 16'($urandom_range(0, 3));
        else cfg_data = 16'($urandom_range(0, 400));
        step();
        cfg_we = 1'b0;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
